// File: rtl/array_seq_ctrl_pkg.sv
// Shared types and constants for the MAC-array west-edge sequencer.
package array_seq_ctrl_pkg;

  typedef enum logic [2:0] {StIdle, StLoad, StGap, StExec, StDrain} state_e;

  // Bit positions inside a per-row {mode, exec, load} instruction.
  localparam int unsigned INST_LOAD = 0;
  localparam int unsigned INST_EXEC = 1;
  localparam int unsigned INST_MODE = 2;
  localparam int unsigned INST_W    = 3;

  localparam int unsigned SRAM_LAT  = 1;

  // 4-bit activation mode packs one weight load per tile, 2-bit mode needs two.
  function automatic int unsigned loads_per_tile(input logic mode);
    return mode ? 1 : 2;
  endfunction

endpackage

// File: rtl/array_seq_ctrl_skew_pipe.sv
// Fixed-depth shift register delaying one row's west-edge inst+data by DEPTH cycles.
module array_seq_ctrl_skew_pipe #(
  parameter int unsigned W     = 7,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [DEPTH-1:0][W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/array_seq_ctrl.sv
// Sequencer for a ROW x COL MAC grid: streams weights then activations from SRAM onto the
// west edge with per-row skew, waits for psum drain and pulses done.
module array_seq_ctrl
  import array_seq_ctrl_pkg::*;
#(
  parameter int unsigned ROW     = 8,
  parameter int unsigned COL     = 8,
  parameter int unsigned BW      = 2,
  parameter int unsigned ADDR_BW = 11,
  parameter int unsigned LEN_BW  = 8,
  parameter int unsigned W_BASE  = 0,
  parameter int unsigned A_BASE  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode_in,
  input  logic [LEN_BW-1:0]     len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_cen,
  output logic [ADDR_BW-1:0]    mem_addr,
  input  logic [ROW*2*BW-1:0]   mem_rdata,
  output logic [ROW*2*BW-1:0]   act_w,
  output logic [ROW*INST_W-1:0] inst_w
);

  localparam int unsigned CW = $clog2(2*COL + ROW + 1);
  localparam int unsigned DW = 2*BW;
  localparam int unsigned SW = INST_W + DW;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [LEN_BW-1:0]               vec_q, vec_d;
  logic [LEN_BW-1:0]               len_q, len_d;
  logic                            mode_q, mode_d;
  logic                            done_q, done_d;
  logic [SRAM_LAT-1:0][INST_W-1:0] inst0_q, inst0_d;
  logic [CW-1:0]                   load_last;
  logic                            rd_load, rd_exec;
  logic [INST_W-1:0]               inst_s0;
  logic                            s0_valid;
  logic [ROW-1:0][SW-1:0]          row_in, row_out;

  assign load_last = CW'(COL * loads_per_tile(mode_q) - 1);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    len_d    = len_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    mem_cen  = 1'b1;
    mem_addr = '0;
    rd_load  = 1'b0;
    rd_exec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode_in;
          len_d   = len;
          cnt_d   = '0;
          vec_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        mem_cen  = 1'b0;
        mem_addr = ADDR_BW'(W_BASE) + ADDR_BW'(cnt_q);
        rd_load  = 1'b1;
        if (cnt_q == load_last) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == CW'(COL - 1)) begin
          cnt_d   = '0;
          state_d = (len_q == '0) ? StDrain : StExec;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StExec: begin
        mem_cen  = 1'b0;
        mem_addr = ADDR_BW'(A_BASE) + ADDR_BW'(vec_q);
        rd_exec  = 1'b1;
        if (vec_q == len_q - 1'b1) begin
          vec_d   = '0;
          state_d = StDrain;
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == CW'(ROW + COL)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Instruction tokens ride alongside the SRAM read so they line up with mem_rdata.
  always_comb begin
    inst0_d               = inst0_q;
    inst0_d[0]            = '0;
    inst0_d[0][INST_LOAD] = rd_load;
    inst0_d[0][INST_EXEC] = rd_exec;
    inst0_d[0][INST_MODE] = busy & mode_q;
    for (int i = 1; i < SRAM_LAT; i++) begin
      inst0_d[i] = inst0_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vec_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      inst0_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      inst0_q <= inst0_d;
    end
  end

  assign inst_s0  = inst0_q[SRAM_LAT-1];
  assign s0_valid = inst_s0[INST_LOAD] | inst_s0[INST_EXEC];

  for (genvar r = 0; r < ROW; r++) begin : g_row
    assign row_in[r] = {inst_s0, s0_valid ? mem_rdata[r*DW +: DW] : {DW{1'b0}}};
    if (r == 0) begin : g_direct
      assign row_out[r] = row_in[r];
    end else begin : g_skew
      array_seq_ctrl_skew_pipe #(
        .W     (SW),
        .DEPTH (r)
      ) u_skew (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (row_in[r]),
        .q_o   (row_out[r])
      );
    end
    assign act_w[r*DW +: DW]          = row_out[r][DW-1:0];
    assign inst_w[r*INST_W +: INST_W] = row_out[r][DW +: INST_W];
  end

endmodule

// File: tb/tb_array_seq_ctrl.sv
// Scoreboard bench: job timelines from the sequencing rules feed expected read, row and done
// queues; a monitor compares every DUT cycle against them.
module tb_array_seq_ctrl;

  localparam int ROW = 3, COL = 2, BW = 2, ADDR_BW = 11, LEN_BW = 8;
  localparam int W_BASE = 0, A_BASE = 64;
  localparam int DW = 2*BW, MW = ROW*DW;

  typedef struct { int cyc; int val; } ev_t;
  typedef struct { int t0; int dn; bit mode; } job_t;

  logic               clk = 1'b0, reset = 1'b1, start = 1'b0, mode_in = 1'b0;
  logic [LEN_BW-1:0]  len = '0;
  logic               busy, done, mem_cen;
  logic [ADDR_BW-1:0] mem_addr;
  logic [MW-1:0]      mem_rdata;
  logic [MW-1:0]      act_w;
  logic [ROW*3-1:0]   inst_w;

  logic [MW-1:0] mem [128];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   free_at = 0, last_t = 0;
  ev_t  aq[$];
  ev_t  rq[ROW][$];
  int   dq[$];
  job_t jobs[$];

  array_seq_ctrl #(
    .ROW(ROW), .COL(COL), .BW(BW), .ADDR_BW(ADDR_BW), .LEN_BW(LEN_BW),
    .W_BASE(W_BASE), .A_BASE(A_BASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in), .len(len),
    .busy(busy), .done(done), .mem_cen(mem_cen), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .act_w(act_w), .inst_w(inst_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!mem_cen) mem_rdata <= mem[mem_addr[6:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cyc %0d: event seen, none expected", nm, cyc);
  endtask

  // Builds the full expected timeline of one job from the start cycle T.
  task automatic run_job(input bit m, input int l, input bit hold_after);
    int loads, t, dn;
    logic [MW-1:0] w;
    logic [2+DW:0] v;
    while (cyc < free_at) @(negedge clk);
    start = 1'b1; mode_in = m; len = LEN_BW'(l);
    t = cyc; last_t = t;
    loads = m ? COL : 2*COL;
    for (int k = 0; k < loads + l; k++) begin
      int a, c;
      a = (k < loads) ? W_BASE + k : A_BASE + (k - loads);
      c = (k < loads) ? t + 1 + k : t + 1 + loads + COL + (k - loads);
      aq.push_back('{c, a});
      w = mem[a];
      for (int r = 0; r < ROW; r++) begin
        v = {m, (k >= loads), (k < loads), w[r*DW +: DW]};
        rq[r].push_back('{c + 1 + r, int'(v)});
      end
    end
    dn = t + loads + 2*COL + l + ROW + 2;
    dq.push_back(dn);
    jobs.push_back('{t, dn, m});
    free_at = dn;
    if (!hold_after) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = MW'($urandom);
    fork
      begin : monitor
        logic [2:0]    ins;
        logic [DW-1:0] d;
        ev_t           e;
        bit            em, eb;
        forever begin
          @(negedge clk);
          if (!reset) begin
            if (!mem_cen) begin
              if (aq.size() == 0) fail("rd_unexpected");
              else begin
                e = aq.pop_front();
                chk("rd_cyc", 64'(cyc), 64'(e.cyc));
                chk("rd_addr", 64'(mem_addr), 64'(e.val));
              end
            end
            eb = 0;
            foreach (jobs[j]) if (cyc >= jobs[j].t0 + 1 && cyc <= jobs[j].dn - 1) eb = 1;
            chk("busy", 64'(busy), 64'(eb));
            for (int r = 0; r < ROW; r++) begin
              ins = inst_w[r*3 +: 3];
              d   = act_w[r*DW +: DW];
              em  = 0;
              foreach (jobs[j])
                if (jobs[j].mode && cyc >= jobs[j].t0 + 2 + r && cyc <= jobs[j].dn + r) em = 1;
              chk($sformatf("row%0d_mode", r), 64'(ins[2]), 64'(em));
              if (ins[0] | ins[1]) begin
                if (rq[r].size() == 0) fail($sformatf("row%0d_ev", r));
                else begin
                  e = rq[r].pop_front();
                  chk($sformatf("row%0d_ev_cyc", r), 64'(cyc), 64'(e.cyc));
                  chk($sformatf("row%0d_ev", r), 64'({ins, d}), 64'(e.val));
                end
              end else begin
                chk($sformatf("row%0d_idle_data", r), 64'(d), 64'(0));
              end
            end
            if (done) begin
              if (dq.size() == 0) fail("done_unexpected");
              else chk("done_cyc", 64'(cyc), 64'(dq.pop_front()));
            end
          end
        end
      end
      begin : stimulus
        #1;
        chk("rst_cen", 64'(mem_cen), 64'(1));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_act", 64'(act_w), 64'(0));
        chk("rst_inst", 64'(inst_w), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        free_at = cyc;
        run_job(0, 3, 0);
        run_job(1, 2, 0);
        run_job(0, 0, 0);
        run_job(1, 1, 1);
        run_job(0, 2, 0);
        // Abort in the middle of EXEC; outputs must clear without waiting for a clock.
        run_job(0, 4, 0);
        while (cyc < last_t + 2*COL + COL + 2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_inst", 64'(inst_w), 64'(0));
        chk("abort_act", 64'(act_w), 64'(0));
        chk("abort_cen", 64'(mem_cen), 64'(1));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        aq.delete();
        for (int r = 0; r < ROW; r++) rq[r].delete();
        dq.delete();
        jobs.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        free_at = cyc;
        repeat (ROW + COL + 6) @(negedge clk);
        free_at = cyc;
        run_job(1, 3, 0);
        for (int i = 0; i < 14; i++)
          run_job($urandom_range(0, 1), $urandom_range(0, 6), $urandom_range(0, 3) == 0);
        @(negedge clk);
        start = 1'b0;
        while (cyc < free_at + ROW + 4) @(negedge clk);
        chk("rd_left", 64'(aq.size()), 64'(0));
        for (int r = 0; r < ROW; r++) chk($sformatf("row%0d_left", r), 64'(rq[r].size()), 64'(0));
        chk("done_left", 64'(dq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      begin : watchdog
        #500000;
        $display("FAIL watchdog @cyc %0d: bench did not complete", cyc);
        $fatal(1, "timeout");
      end
    join
  end

endmodule
